lift_shaft_model: RTL and testbench
===================================

// Module: lift_shaft_model
// PURPOSE
//  Car/shaft side of the lift motor/sensor interface. Receives motor_up/motor_down from the lift
//  controller, moves a discrete car position counter, and drives the floor position sensors
//  (bottom, middle_minus, middle_plus, top) back to the controller. Closes the loop for
//  simulation and FPGA demo. Flags illegal motor commands.
// PARAMETERS
//  STEPS_PER_FLOOR  8  position steps between adjacent floors; MAX_POS = 2*STEPS_PER_FLOOR
//  TICKS_PER_STEP   4  clocks of continuous motor command per position step (>=1)
//  MID_WINDOW       1  half-width, in steps, of the middle-floor sensor zones (< STEPS_PER_FLOOR)
//  INIT_FLOOR       0  reset floor, 0..2; reset position = INIT_FLOOR*STEPS_PER_FLOOR
//  DOOR_CYCLES      16 door-open dwell in clocks (used only with LIFT_DOOR_EN)
// PORTS
//  clk              in   1      rising-edge clock
//  reset_n          in   1      asynchronous, active-low reset
//  motor_up         in   1      drive car upward
//  motor_down       in   1      drive car downward
//  fault_clr        in   1      clears sticky fault flags; leaves FAULT state
//  bottom           out  1      position == 0
//  middle_minus     out  1      position in [STEPS_PER_FLOOR-MID_WINDOW, STEPS_PER_FLOOR]
//  middle_plus      out  1      position in [STEPS_PER_FLOOR, STEPS_PER_FLOOR+MID_WINDOW]
//  top              out  1      position == MAX_POS
//  position         out  POS_W  car position, POS_W = $clog2(MAX_POS+1)
//  moving           out  1      state is MOVING_UP or MOVING_DOWN
//  fault_overtravel out  1      sticky: step requested beyond 0 or MAX_POS
//  fault_conflict   out  1      sticky: motor_up and motor_down sampled high together
//  door_open        out  1      (LIFT_DOOR_EN only) door open at a floor
//  door_blocked     out  1      (LIFT_DOOR_EN only) 1-cycle pulse: motor command rejected by door
// BEHAVIOUR
//  - Reset (async): position=INIT_FLOOR*STEPS_PER_FLOOR, state=IDLE, tick counter=0, faults=0,
//    moving=0, door_open=0, door_blocked=0. Sensor outputs are combinational decodes of position.
//  - Exact middle floor: middle_minus=middle_plus=1. Inside one window only: only that sensor.
//  - FSM: IDLE, MOVING_UP, MOVING_DOWN, FAULT. Commands are sampled each rising edge.
//    IDLE/MOVING_*: up&!down -> MOVING_UP; down&!up -> MOVING_DOWN; neither -> IDLE;
//    both -> FAULT, fault_conflict=1 on that edge. FAULT: position frozen; exit to IDLE only on
//    an edge with fault_clr=1, motor_up=0 and motor_down=0.
//  - Stepping: in MOVING_* the tick counter increments each clock; when it equals
//    TICKS_PER_STEP-1 it wraps to 0 and position moves +/-1. A command first sampled at edge k
//    moves position at edge k+TICKS_PER_STEP. Command held -> one step per TICKS_PER_STEP clocks.
//  - Entry into IDLE, FAULT, or direct direction reversal clears the tick counter; partial steps
//    are discarded, position unchanged.
//  - Limits: step due at MAX_POS going up or at 0 going down -> position held,
//    fault_overtravel=1 on that edge; state unchanged; no wrap-around ever.
//  - fault_clr clears both flags on the edge it is sampled, unless the same edge sets one
//    (set wins).
// CONFIGURATION
//  LIFT_DOOR_EN defined: on entering IDLE with position in {0, STEPS_PER_FLOOR, MAX_POS}, door_open=1
//   for DOOR_CYCLES clocks. While door_open, motor commands are ignored (state stays IDLE) and
//   door_blocked pulses for each edge a command is sampled; conflict detection still applies.
//  LIFT_DOOR_EN undefined: door_open/door_blocked ports and door timer absent; behaviour as above.
// STRUCTURE
//  Package lift_pkg: state enum (IDLE/MOVING_UP/MOVING_DOWN/FAULT), floor index constants
//  FLOOR_GROUND=0/FLOOR_FIRST=1/FLOOR_SECOND=2, sensor bit-index constants.
//  Sub-module lift_step_prescaler: tick counter with clear, enable, and step_pulse output.
// TESTING (defaults STEPS_PER_FLOOR=8, TICKS_PER_STEP=4, MID_WINDOW=1, INIT_FLOOR=0)
//  1 reset, motor_up held 64 clocks -> position 0->16 in 4-clk steps; bottom=1 at 0;
//    middle_minus only at 7; both middle sensors at 8; middle_plus only at 9; top at 16.
//  2 at 16, motor_up held 8 more clocks -> position stays 16, fault_overtravel=1 at 4th edge;
//    fault_clr with motors low -> flag 0.
//  3 motor_up 3 clocks then motor_down -> position unchanged until 4 clocks of down, then -1.
//  4 motor_up=motor_down=1 one clock at pos 5 -> FAULT, fault_conflict=1, pos frozen;
//    fault_clr with up=1 -> stays FAULT; fault_clr with motors low -> IDLE.
//  5 reset_n low mid-step at pos 11 -> position=0, all flags 0 immediately, no clock needed.
//  6 LIFT_DOOR_EN: stop at 8 -> door_open 16 clocks; motor_up during that -> door_blocked, no move.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and constants for the lift shaft model: FSM state encoding,
// floor indices and bit positions within the packed sensor vector.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MOVING_UP   = 2'd1,
        MOVING_DOWN = 2'd2,
        FAULT       = 2'd3
    } lift_state_e;

    localparam int FLOOR_GROUND = 0;
    localparam int FLOOR_FIRST  = 1;
    localparam int FLOOR_SECOND = 2;

    localparam int SENS_BOTTOM    = 0;
    localparam int SENS_MID_MINUS = 1;
    localparam int SENS_MID_PLUS  = 2;
    localparam int SENS_TOP       = 3;
    localparam int SENS_W         = 4;

endpackage

// File: rtl/lift_step_prescaler.sv
// Divides a continuous motor command into position steps: one step_pulse per
// TICKS_PER_STEP enabled clocks, restarting from zero whenever clr is high.
module lift_step_prescaler #(
    parameter int TICKS_PER_STEP = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic step_pulse
);

    localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_STEP - 1);

    logic [CNT_W-1:0] cnt;

    assign step_pulse = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lift_shaft_model.sv
// Car/shaft side of the lift: moves a position counter from motor commands and
// decodes floor sensors. Optional door dwell is enabled with LIFT_DOOR_EN.
module lift_shaft_model
    import lift_pkg::*;
#(
    parameter int STEPS_PER_FLOOR = 8,
    parameter int TICKS_PER_STEP  = 4,
    parameter int MID_WINDOW      = 1,
    parameter int INIT_FLOOR      = 0,
    parameter int DOOR_CYCLES     = 16,
    localparam int MAX_POS        = 2 * STEPS_PER_FLOOR,
    localparam int POS_W          = $clog2(MAX_POS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             motor_up,
    input  logic             motor_down,
    input  logic             fault_clr,
    output logic             bottom,
    output logic             middle_minus,
    output logic             middle_plus,
    output logic             top,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             fault_overtravel,
    output logic             fault_conflict,
`ifdef LIFT_DOOR_EN
    output logic             door_open,
    output logic             door_blocked,
`endif
    output lift_state_e      dbg_state
);

    localparam logic [POS_W-1:0] INIT_POS = POS_W'(INIT_FLOOR * STEPS_PER_FLOOR);
    localparam logic [POS_W-1:0] MID_POS  = POS_W'(STEPS_PER_FLOOR);
    localparam logic [POS_W-1:0] MID_LO   = POS_W'(STEPS_PER_FLOOR - MID_WINDOW);
    localparam logic [POS_W-1:0] MID_HI   = POS_W'(STEPS_PER_FLOOR + MID_WINDOW);
    localparam logic [POS_W-1:0] TOP_POS  = POS_W'(MAX_POS);

    lift_state_e       state;
    logic [SENS_W-1:0] sens;
    logic              cmd_up, cmd_down, conflict;
    logic              step_en, step_pulse, overtravel, enter_idle, door_busy;

    assign cmd_up   = motor_up && !motor_down;
    assign cmd_down = motor_down && !motor_up;
    assign conflict = motor_up && motor_down;

    // The prescaler only runs while the same direction stays commanded;
    // any other edge discards the partial step.
    assign step_en    = (state == MOVING_UP && cmd_up) || (state == MOVING_DOWN && cmd_down);
    assign overtravel = step_pulse && ((state == MOVING_UP && position == TOP_POS) ||
                                       (state == MOVING_DOWN && position == '0));
    assign enter_idle = ((state == MOVING_UP || state == MOVING_DOWN) && !motor_up && !motor_down) ||
                        (state == FAULT && fault_clr && !motor_up && !motor_down);

    lift_step_prescaler #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (!step_en),
        .en         (step_en),
        .step_pulse (step_pulse)
    );

    always_comb begin
        sens                 = '0;
        sens[SENS_BOTTOM]    = (position == '0);
        sens[SENS_MID_MINUS] = (position >= MID_LO) && (position <= MID_POS);
        sens[SENS_MID_PLUS]  = (position >= MID_POS) && (position <= MID_HI);
        sens[SENS_TOP]       = (position == TOP_POS);
    end

    assign bottom       = sens[SENS_BOTTOM];
    assign middle_minus = sens[SENS_MID_MINUS];
    assign middle_plus  = sens[SENS_MID_PLUS];
    assign top          = sens[SENS_TOP];
    assign moving       = (state == MOVING_UP) || (state == MOVING_DOWN);
    assign dbg_state    = state;

`ifdef LIFT_DOOR_EN
    localparam int DT_W = $clog2(DOOR_CYCLES + 1);
    logic [DT_W-1:0] door_timer;
    logic            at_floor;
    assign at_floor  = (position == '0) || (position == MID_POS) || (position == TOP_POS);
    assign door_busy = (door_timer != '0);
    assign door_open = door_busy;
`else
    assign door_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            position         <= INIT_POS;
            fault_overtravel <= 1'b0;
            fault_conflict   <= 1'b0;
`ifdef LIFT_DOOR_EN
            door_timer       <= '0;
            door_blocked     <= 1'b0;
`endif
        end else begin
            case (state)
                FAULT: begin
                    if (fault_clr && !motor_up && !motor_down) state <= IDLE;
                end
                default: begin
                    if (conflict)       state <= FAULT;
                    else if (door_busy) state <= IDLE;
                    else if (cmd_up)    state <= MOVING_UP;
                    else if (cmd_down)  state <= MOVING_DOWN;
                    else                state <= IDLE;
                end
            endcase

            if (step_pulse && !overtravel) begin
                position <= (state == MOVING_UP) ? position + POS_W'(1) : position - POS_W'(1);
            end

            // Set wins over a clear sampled on the same edge.
            fault_overtravel <= overtravel || (fault_overtravel && !fault_clr);
            fault_conflict   <= conflict || (fault_conflict && !fault_clr);

`ifdef LIFT_DOOR_EN
            door_blocked <= (state == IDLE) && door_busy && (cmd_up || cmd_down);
            if (conflict) begin
                door_timer <= '0;
            end else if (enter_idle && at_floor) begin
                door_timer <= DT_W'(DOOR_CYCLES);
            end else if (door_busy) begin
                door_timer <= door_timer - DT_W'(1);
            end
`endif
        end
    end

    logic unused_ok;
    assign unused_ok = enter_idle;

endmodule

// File: tb/tb_lift_shaft_model.sv
// Self-checking bench for lift_shaft_model: directed scenarios pinned by literal
// values, then randomized command streams checked against a behavioural model.
module tb_lift_shaft_model;
    import lift_pkg::*;

    localparam int SPF     = 8;
    localparam int TPS     = 4;
    localparam int MW      = 1;
    localparam int MAX_POS = 2 * SPF;
    localparam int POS_W   = $clog2(MAX_POS + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic motor_up = 1'b0;
    logic motor_down = 1'b0;
    logic fault_clr = 1'b0;
    logic bottom, middle_minus, middle_plus, top, moving;
    logic fault_overtravel, fault_conflict;
    logic [POS_W-1:0] position;
    lift_state_e dbg_state;
`ifdef LIFT_DOOR_EN
    logic door_open, door_blocked;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 0;

    // Behavioural model: direction of the current uninterrupted command run and
    // how many edges it has been held; a step is due every TPS edges of that run.
    int m_pos, m_dir, m_age;
    bit m_fault, m_fo, m_fc;

    lift_shaft_model dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .motor_up         (motor_up),
        .motor_down       (motor_down),
        .fault_clr        (fault_clr),
        .bottom           (bottom),
        .middle_minus     (middle_minus),
        .middle_plus      (middle_plus),
        .top              (top),
        .position         (position),
        .moving           (moving),
        .fault_overtravel (fault_overtravel),
        .fault_conflict   (fault_conflict),
`ifdef LIFT_DOOR_EN
        .door_open        (door_open),
        .door_blocked     (door_blocked),
`endif
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_age = 0;
        m_fault = 0; m_fo = 0; m_fc = 0;
    endtask

    task automatic model_edge(input bit u, input bit d, input bit c);
        bit set_c, set_o;
        int nd;
        set_c = u && d;
        set_o = 0;
        if (m_fault) begin
            if (c && !u && !d) m_fault = 0;
        end else if (set_c) begin
            m_fault = 1; m_dir = 0; m_age = 0;
        end else begin
            nd = u ? 1 : (d ? -1 : 0);
            if (nd != 0 && nd == m_dir) begin
                m_age++;
                if (m_age % TPS == 0) begin
                    if (m_pos + nd < 0 || m_pos + nd > MAX_POS) set_o = 1;
                    else m_pos = m_pos + nd;
                end
            end else begin
                m_dir = nd; m_age = 0;
            end
        end
        m_fc = set_c || (m_fc && !c);
        m_fo = set_o || (m_fo && !c);
    endtask

    function automatic int exp_state();
        if (m_fault) return int'(FAULT);
        if (m_dir > 0) return int'(MOVING_UP);
        if (m_dir < 0) return int'(MOVING_DOWN);
        return int'(IDLE);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_edge(motor_up, motor_down, fault_clr);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && check_en) begin
                chk("cmp_position", int'(position), m_pos);
                chk("cmp_bottom", int'(bottom), int'(m_pos == 0));
                chk("cmp_mid_minus", int'(middle_minus), int'(m_pos >= SPF - MW && m_pos <= SPF));
                chk("cmp_mid_plus", int'(middle_plus), int'(m_pos >= SPF && m_pos <= SPF + MW));
                chk("cmp_top", int'(top), int'(m_pos == MAX_POS));
                chk("cmp_moving", int'(moving), int'(!m_fault && m_dir != 0));
                chk("cmp_overtravel", int'(fault_overtravel), int'(m_fo));
                chk("cmp_conflict", int'(fault_conflict), int'(m_fc));
                chk("cmp_state", int'(dbg_state), exp_state());
            end
        end
    end

    task automatic cyc(input bit u, input bit d, input bit c);
        @(negedge clk);
        motor_up = u; motor_down = d; fault_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic move_to(input int target);
        int n;
        bit up;
        n = 0;
        up = (target > m_pos);
        while (m_pos != target && n < 400) begin
            cyc(up, !up, 1'b0);
            n++;
        end
        if (m_pos != target) chk("move_to_timeout", m_pos, target);
    endtask

    function automatic int sens4();
        return {28'd0, bottom, middle_minus, middle_plus, top};
    endfunction

    initial begin
        int kind, len;
        bit u, d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_en = 1;
        #1;
        chk("reset_position", int'(position), 0);
        chk("reset_sensors", sens4(), 4'b1000);
        chk("reset_flags", int'({moving, fault_overtravel, fault_conflict}), 0);

        // Climb the full shaft, one step per TPS edges after the first sampled edge.
        for (int e = 1; e <= 65; e++) begin
            cyc(1'b1, 1'b0, 1'b0);
            case (e)
                1:  chk("t1_e1_moving_at_0", int'({moving, bottom}), 2'b11);
                4:  chk("t1_e4_pos", int'(position), 0);
                5:  chk("t1_e5_pos", int'(position), 1);
                29: chk("t1_pos7_sens", sens4(), 4'b0100);
                33: chk("t1_pos8_sens", sens4(), 4'b0110);
                37: chk("t1_pos9_sens", sens4(), 4'b0010);
                65: chk("t1_pos16_sens", sens4(), 4'b0001);
                default: ;
            endcase
        end
        chk("t1_final_pos", int'(position), 16);

        for (int e = 1; e <= 8; e++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (e == 3) chk("t2_no_ovt_yet", int'(fault_overtravel), 0);
            if (e == 4) chk("t2_ovt_set", int'({position, fault_overtravel}), (16 << 1) | 1);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("t2_ovt_cleared", int'(fault_overtravel), 0);
        chk("t2_idle", int'(dbg_state), int'(IDLE));

        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        for (int b = 1; b <= 5; b++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (b == 4) chk("t3_pos_held", int'(position), 16);
            if (b == 5) chk("t3_pos_dec", int'(position), 15);
        end

        move_to(5);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t4_fault_state", int'(dbg_state), int'(FAULT));
        chk("t4_conflict_flag", int'(fault_conflict), 1);
        repeat (6) cyc(1'b1, 1'b0, 1'b0);
        chk("t4_pos_frozen", int'(position), 5);
        cyc(1'b1, 1'b0, 1'b1);
        chk("t4_clr_with_up_stays", int'(dbg_state), int'(FAULT));
        cyc(1'b0, 1'b0, 1'b1);
        chk("t4_clr_exits", int'(dbg_state), int'(IDLE));

        move_to(11);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_pos", int'(position), 0);
        chk("t5_async_flags", int'({moving, fault_overtravel, fault_conflict}), 0);
        chk("t5_async_state", int'(dbg_state), int'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        motor_up = 1'b0;

        for (int seg = 0; seg < 150; seg++) begin
            kind = int'($urandom_range(0, 99));
            len  = int'($urandom_range(1, 40));
            if (kind < 45)      begin u = 1; d = 0; end
            else if (kind < 80) begin u = 0; d = 1; end
            else if (kind < 92) begin u = 0; d = 0; end
            else                begin u = 1; d = 1; len = 1; end
            for (int i = 0; i < len; i++) begin
                cyc(u, d, ($urandom_range(0, 9) == 0));
            end
        end

        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
